// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

  localparam int unsigned BASE_ADDER_SIZE = 4;

endpackage

// File: rtl/nBitCarryLookAheadAdder.sv
// NUMBITS-wide adder: 4-bit carry-lookahead blocks, carry rippled block to block.
module nBitCarryLookAheadAdder
  import mult_pkg::*;
#(
  parameter int unsigned NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] a_in,
  input  logic [NUMBITS-1:0] b_in,
  input  logic               c_in,
  output logic [NUMBITS-1:0] s_out,
  output logic               c_out
);

  localparam int unsigned NBLK = NUMBITS / BASE_ADDER_SIZE;

  logic [NBLK:0] w_carry;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g    = a_in[4*i +: 4] & b_in[4*i +: 4];
    assign w_p    = a_in[4*i +: 4] ^ b_in[4*i +: 4];
    assign w_c[0] = w_carry[i];
    // Fully expanded lookahead terms so no carry ripples inside the block.
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign s_out[4*i +: 4] = w_p ^ w_c[3:0];
    assign w_carry[i+1]    = w_c[4];
  end

  assign c_out = w_carry[NBLK];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NUMBITS x NUMBITS multiplier, one shift-and-add step per clock,
// with ready/valid handshakes on operands and result.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned NUMBITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUMBITS-1:0]     a_in,
  input  logic [NUMBITS-1:0]     b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*NUMBITS-1:0]   product_out,
  output logic                   busy
);

  if ((NUMBITS % BASE_ADDER_SIZE) != 0) begin : g_bad_width
    $error("shift_add_multiplier: NUMBITS=%0d is not a multiple of %0d",
           NUMBITS, BASE_ADDER_SIZE);
  end

  localparam int unsigned CW = (NUMBITS > 1) ? $clog2(NUMBITS) : 1;

  mult_state_t            r_state;
  mult_state_t            w_state_next;
  logic [NUMBITS-1:0]     r_a;
  logic [2*NUMBITS-1:0]   r_p;
  logic [2*NUMBITS-1:0]   r_product;
  logic [CW-1:0]          r_count;

  logic [NUMBITS-1:0]     w_hi;
  logic [NUMBITS-1:0]     w_add_a;
  logic [NUMBITS-1:0]     w_add_b;
  logic [NUMBITS-1:0]     w_sum;
  logic                   w_carry;
  logic [2*NUMBITS-1:0]   w_p_next;
  logic                   w_last;

  assign w_hi   = r_p[2*NUMBITS-1:NUMBITS];
  assign w_last = (r_count == CW'(NUMBITS - 1));

  // Adder inputs are held at zero outside RUN to keep it quiet.
  assign w_add_a = (r_state == RUN) ? w_hi : '0;
  assign w_add_b = (r_state == RUN) ? r_a  : '0;

  nBitCarryLookAheadAdder #(
    .NUMBITS (NUMBITS)
  ) u_adder (
    .a_in  (w_add_a),
    .b_in  (w_add_b),
    .c_in  (1'b0),
    .s_out (w_sum),
    .c_out (w_carry)
  );

  // Adder carry becomes the new MSB, so the shifted product never overflows.
  assign w_p_next = r_p[0] ? {w_carry, w_sum, r_p[NUMBITS-1:1]}
                           : {1'b0, w_hi, r_p[NUMBITS-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_p       <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a_in;
            r_p     <= {{NUMBITS{1'b0}}, b_in};
            r_count <= '0;
          end
        end
        RUN: begin
          r_p     <= w_p_next;
          r_count <= r_count + CW'(1);
          if (w_last) r_product <= w_p_next;
        end
        default: ;
      endcase
    end
  end

  assign product_out = r_product;

endmodule
